// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: shares one character-LCD byte-write controller between
// two requesters. It grants them round-robin, runs the start/done handshake
// and then holds off for DLY_CYCLES so the LCD can finish executing the byte.
// Optional feature macro: LCD_ARB_TIMEOUT_EN adds a done watchdog and the
// oTMO port. Without it, WAIT_DONE waits for iDONE indefinitely.
module lcd_write_arbiter #(
    parameter int DLY_CYCLES     = 262142,
    parameter int DLY_W          = 18,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iREQ0,
    input  logic [7:0] iDATA0,
    input  logic       iRS0,
    output logic       oACK0,
    input  logic       iREQ1,
    input  logic [7:0] iDATA1,
    input  logic       iRS1,
    output logic       oACK1,
    output logic [7:0] oDATA,
    output logic       oRS,
    output logic       oSTART,
    input  logic       iDONE,
    output logic       oBUSY,
    output logic       oGNT
`ifdef LCD_ARB_TIMEOUT_EN
    ,
    output logic       oTMO
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYCLES);

    logic [1:0]       r_state;
    logic [DLY_W-1:0] r_cnt;
    logic             r_last;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_start;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_busy;
    logic             r_gnt;

    logic             w_any;
    logic             w_gnt;
    logic             w_expire;

    // With both requesting, serve the one that was not served last.
    assign w_any = iREQ0 | iREQ1;
    assign w_gnt = (iREQ0 & iREQ1) ? ~r_last : ~iREQ0;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_wd;
    logic             r_tmo;

    // The watchdog expires on the TIMEOUT_CYCLES-th WAIT_DONE cycle without iDONE.
    assign w_expire = (r_state == S_WAIT) && (r_wd == TMO_LAST);
    assign oTMO     = r_tmo;

    // Count WAIT_DONE cycles; iDONE wins if it arrives on the expiry edge.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wd  <= '0;
            r_tmo <= 1'b0;
        end else begin
            r_tmo <= w_expire && !iDONE;
            if ((r_state == S_WAIT) && !iDONE) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    assign oDATA  = r_data;
    assign oRS    = r_rs;
    assign oSTART = r_start;
    assign oACK0  = r_ack0;
    assign oACK1  = r_ack1;
    assign oBUSY  = r_busy;
    assign oGNT   = r_gnt;

    // Grant, start/done handshake and post-byte hold-off sequencing.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_start <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
            r_gnt   <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_data  <= w_gnt ? iDATA1 : iDATA0;
                        r_rs    <= w_gnt ? iRS1 : iRS0;
                        r_start <= 1'b1;
                        r_gnt   <= w_gnt;
                        r_last  <= w_gnt;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iDONE || w_expire) begin
                        r_start <= 1'b0;
                        r_ack0  <= ~r_gnt;
                        r_ack1  <= r_gnt;
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == DLY_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: random requesters and a random-latency
// controller drive the main instance; a transaction-level model predicts each
// grant and acknowledge, and a monitor compares them as the DUT produces them.
// A second instance with zero hold-off covers the back-to-back timing case.
module tb_lcd_write_arbiter;

    localparam int DLY = 4;
    localparam int TMO = 16;

    typedef struct {
        int         g;
        logic [7:0] d;
        logic       rs;
        int         cyc;
    } st_t;

    typedef struct {
        int g;
        int cyc;
        bit tmo;
    } ak_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req [2];
    logic [7:0] data [2];
    logic       rs [2];
    logic       done;
    logic       oACK0, oACK1, oSTART, oBUSY, oGNT, oRS;
    logic [7:0] oDATA;
    logic       ack [2];

    logic       z_rst, z_req, z_rs, z_done;
    logic [7:0] z_data;
    logic       z_ack0, z_ack1, z_start, z_busy, z_gnt, z_ors;
    logic [7:0] z_odata;

`ifdef LCD_ARB_TIMEOUT_EN
    logic oTMO;
    logic z_tmo;
`endif

    int checks = 0;
    int errors = 0;

    bit ctl_en  = 1'b1;
    bit spur_en = 1'b0;
    bit fair    = 1'b1;
    bit stop    = 1'b0;
    bit z_fin   = 1'b0;

    // model state
    int  cyc     = 0;
    bit  m_rst   = 1'b0;
    bit  m_busy  = 1'b0;
    int  m_ready = 0;
    int  m_last  = 1;
    int  m_gnt   = 0;
    int  m_gcyc  = 0;
    st_t q_start[$];
    ak_t q_ack[$];
    int  glog[$];
    int  n_tmo   = 0;
    bit  prev_start = 1'b0;

    always #5 clk = ~clk;

    assign ack[0] = oACK0;
    assign ack[1] = oACK1;

    lcd_write_arbiter #(.DLY_CYCLES(DLY), .DLY_W(18), .TIMEOUT_CYCLES(TMO)) u_dut (
        .iCLK(clk), .iRST(rst),
        .iREQ0(req[0]), .iDATA0(data[0]), .iRS0(rs[0]), .oACK0(oACK0),
        .iREQ1(req[1]), .iDATA1(data[1]), .iRS1(rs[1]), .oACK1(oACK1),
        .oDATA(oDATA), .oRS(oRS), .oSTART(oSTART), .iDONE(done),
        .oBUSY(oBUSY), .oGNT(oGNT)
`ifdef LCD_ARB_TIMEOUT_EN
        , .oTMO(oTMO)
`endif
    );

    lcd_write_arbiter #(.DLY_CYCLES(0), .DLY_W(18), .TIMEOUT_CYCLES(65535)) u_zero (
        .iCLK(clk), .iRST(z_rst),
        .iREQ0(z_req), .iDATA0(z_data), .iRS0(z_rs), .oACK0(z_ack0),
        .iREQ1(1'b0), .iDATA1(8'h00), .iRS1(1'b0), .oACK1(z_ack1),
        .oDATA(z_odata), .oRS(z_ors), .oSTART(z_start), .iDONE(z_done),
        .oBUSY(z_busy), .oGNT(z_gnt)
`ifdef LCD_ARB_TIMEOUT_EN
        , .oTMO(z_tmo)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one byte at a time; grant at the first sampling edge
    // with a request, round-robin on ties; after completion the next sampling
    // edge is DLY+2 edges later.
    always @(posedge clk) begin
        bit tmo_hit;
        int g;
        if (rst) begin
            m_rst   = 1'b1;
            m_busy  = 1'b0;
            m_last  = 1;
            m_ready = cyc + 1;
            q_start.delete();
            q_ack.delete();
        end else begin
            m_rst = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
            tmo_hit = m_busy && ((cyc - m_gcyc) == TMO);
`else
            tmo_hit = 1'b0;
`endif
            if (m_busy) begin
                if (done || tmo_hit) begin
                    q_ack.push_back('{g: m_gnt, cyc: cyc, tmo: !done});
                    m_busy  = 1'b0;
                    m_ready = cyc + DLY + 2;
                end
            end else if (cyc >= m_ready && (req[0] || req[1])) begin
                if (req[0] && req[1]) g = 1 - m_last;
                else g = req[0] ? 0 : 1;
                q_start.push_back('{g: g, d: data[g], rs: rs[g], cyc: cyc});
                m_last = g;
                m_gnt  = g;
                m_gcyc = cyc;
                m_busy = 1'b1;
            end
        end
        cyc++;
    end

    // Monitor: compares what the DUT presents against the model's queues.
    always @(negedge clk) begin
        st_t s;
        ak_t a;
        if (m_rst) begin
            chk("reset_outputs", 32'({oDATA, oRS, oSTART, oACK0, oACK1, oBUSY, oGNT}), 32'd0);
        end else begin
            chk("start_busy", 32'({oSTART, oBUSY}), 32'({m_busy, (m_busy || (cyc < m_ready))}));
            if (oSTART && !prev_start) begin
                chk("start_expected", 32'(q_start.size() > 0), 32'd1);
                if (q_start.size() > 0) begin
                    s = q_start.pop_front();
                    chk("grant_idx", 32'(oGNT), 32'(s.g));
                    chk("grant_data", 32'(oDATA), 32'(s.d));
                    chk("grant_rs", 32'(oRS), 32'(s.rs));
                    chk("grant_cycle", 32'(cyc), 32'(s.cyc + 1));
                    glog.push_back(int'(oGNT));
                end
            end
            if (oACK0 || oACK1) begin
                chk("ack_expected", 32'(q_ack.size() > 0), 32'd1);
                if (q_ack.size() > 0) begin
                    a = q_ack.pop_front();
                    chk("ack_which", 32'({oACK1, oACK0}), 32'(1 << a.g));
                    chk("ack_cycle", 32'(cyc), 32'(a.cyc + 1));
                    chk("ack_gnt", 32'(oGNT), 32'(a.g));
`ifdef LCD_ARB_TIMEOUT_EN
                    chk("ack_tmo", 32'(oTMO), 32'(a.tmo));
                    if (a.tmo) n_tmo++;
`endif
                end
            end
`ifdef LCD_ARB_TIMEOUT_EN
            chk("tmo_without_ack", 32'(oTMO && !(oACK0 || oACK1)), 32'd0);
`endif
        end
        prev_start = oSTART;
    end

    // Controller emulation: iDONE a random number of cycles after oSTART,
    // optional stray iDONE pulses while no byte is in flight.
    always @(negedge clk) begin
        int lat_left;
        if (!ctl_en) begin
            done = 1'b0;
            lat_left = -1;
        end else if (oSTART) begin
            if (lat_left < 0) lat_left = $urandom_range(0, 4);
            if (lat_left > 0) begin
                done = 1'b0;
                lat_left--;
            end else begin
                done = 1'b1;
            end
        end else begin
            lat_left = -1;
            done = spur_en && ($urandom_range(0, 7) == 0);
        end
    end

    task automatic requester(input int n);
        forever begin
            int waited;
            int gap;
            @(negedge clk);
            if (stop && !req[n]) continue;
            if (!req[n]) begin
                gap = fair ? 0 : $urandom_range(0, 8);
                repeat (gap) @(negedge clk);
                if (stop) continue;
                data[n] = 8'($urandom);
                rs[n]   = 1'($urandom);
                req[n]  = 1'b1;
            end
            waited = 0;
            while (!ack[n] && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            if (!ack[n]) chk($sformatf("ack_wait_req%0d", n), 32'd0, 32'd1);
            req[n] = 1'b0;
        end
    endtask

    initial requester(0);
    initial requester(1);

    // Zero hold-off instance: back-to-back bytes from requester 0.
    initial begin
        int n;
        z_rst = 1'b1; z_req = 1'b0; z_data = 8'h0C; z_rs = 1'b0; z_done = 1'b0;
        repeat (2) @(negedge clk);
        z_rst = 1'b0;
        z_req = 1'b1;
        n = 0;
        while (!z_start && n < 20) begin @(negedge clk); n++; end
        chk("z_first_start", 32'(z_start), 32'd1);
        chk("z_first_data", 32'(z_odata), 32'h0C);
        z_done = 1'b1;
        @(negedge clk);
        z_done = 1'b0;
        chk("z_first_ack", 32'({z_ack1, z_ack0, z_start}), 32'b010);
        z_data = 8'h01;
        n = 0;
        while (!z_start && n < 10) begin @(negedge clk); n++; end
        chk("z_restart_gap", 32'(n), 32'd2);
        chk("z_second_data", 32'(z_odata), 32'h01);
        z_done = 1'b1;
        @(negedge clk);
        z_done = 1'b0;
        chk("z_second_ack", 32'({z_ack1, z_ack0, z_gnt}), 32'b010);
        z_req = 1'b0;
        z_fin = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int base;
        rst = 1'b1;
        req[0] = 1'b1; data[0] = 8'h38; rs[0] = 1'b0;
        req[1] = 1'b1; data[1] = 8'h44; rs[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // continuous requests from both: strict alternation from requester 0
        n = 0;
        while (glog.size() < 6 && n < 300) begin @(negedge clk); n++; end
        chk("fair_count", 32'(glog.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk($sformatf("fair_gnt%0d", i), 32'(glog[i]), 32'(i % 2));

        fair = 1'b0; spur_en = 1'b1;
        repeat (300) @(negedge clk);

        // reset while a byte is waiting for done
        fair = 1'b1;
        repeat (12) @(negedge clk);
        n = 0;
        while (!oSTART && n < 100) begin @(negedge clk); n++; end
        chk("midrst_in_wait", 32'(oSTART), 32'd1);
        base = glog.size();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (glog.size() <= base && n < 100) begin @(negedge clk); n++; end
        chk("midrst_regrant", 32'(glog.size() > base), 32'd1);
        if (glog.size() > base) chk("midrst_first_gnt", 32'(glog[base]), 32'd0);

        fair = 1'b0;
        repeat (200) @(negedge clk);

`ifdef LCD_ARB_TIMEOUT_EN
        ctl_en = 1'b0; spur_en = 1'b0;
        repeat (150) @(negedge clk);
        chk("tmo_seen", 32'(n_tmo >= 3), 32'd1);
        ctl_en = 1'b1;
`endif

        stop = 1'b1; spur_en = 1'b0;
        repeat (120) @(negedge clk);
        chk("drain_start_q", 32'(q_start.size()), 32'd0);
        chk("drain_ack_q", 32'(q_ack.size()), 32'd0);
        chk("drain_idle", 32'(oBUSY), 32'd0);

        n = 0;
        while (!z_fin && n < 200) begin @(negedge clk); n++; end
        chk("zero_dly_done", 32'(z_fin), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
